sorter_batch_ctrl: RTL

SORTER_BATCH_CTRL -- requirements
Module: sorter_batch_ctrl

---
 rtl/sorter_batch_ctrl_if.sv | 33 +++
 rtl/sorter_batch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sorter_batch_ctrl_if.sv
// ---------------------------------------------------------------------------
// sorter_batch_ctrl_if
// Stream bundle between the batch controller and its neighbours.
//   s_data/s_valid/s_last -> upstream element into the controller
//   s_ready               <- controller accepts the element
//   m_data/m_valid/m_last <- sorted output stream (no backpressure)
// Modports:
//   master : producer/consumer side (testbench or surrounding logic)
//   slave  : the sorter_batch_ctrl block
// ---------------------------------------------------------------------------
interface sorter_batch_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready,
        input  m_data, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready,
        output m_data, m_valid, m_last
    );
endinterface

// File: rtl/sorter_batch_ctrl.sv
// ---------------------------------------------------------------------------
// sorter_batch_ctrl
// Batches upstream elements into an external sorter, flushes the sorter and
// forwards the sorted stream, then resets the sorter for the next batch.
//
// Ports:
//   clk, nreset       clock, synchronous active-low reset
//   bus (slave)       s_data/s_valid/s_last/s_ready in, m_data/m_valid/m_last out
//   srt_data_i(_v)    element and insert strobe to the sorter
//   srt_flush         sorter flush, high for the whole FLUSH state
//   srt_rst           sorter reset, high during nreset=0 and in CLEAR
//   srt_data_o(_v)    sorted data from the sorter
//   busy              controller not in IDLE
//   err               one-cycle pulse when a drain times out
//   batch_cnt,        (only with SORTER_CTRL_STATS_EN) saturating counts of
//   tmo_cnt_total      completed batches and of drain timeouts
//
// Optional feature macro: SORTER_CTRL_STATS_EN
// ---------------------------------------------------------------------------
module sorter_batch_ctrl #(
    parameter int N     = 22,
    parameter int WIDTH = 8,
    parameter int TMO   = 2*N+4
) (
    input  logic               clk,
    input  logic               nreset,
    sorter_batch_ctrl_if.slave bus,
    output logic [WIDTH-1:0]   srt_data_i,
    output logic               srt_data_i_v,
    output logic               srt_flush,
    output logic               srt_rst,
    input  logic [WIDTH-1:0]   srt_data_o,
    input  logic               srt_data_o_v,
    output logic               busy,
    output logic               err
`ifdef SORTER_CTRL_STATS_EN
    ,
    output logic [15:0]        batch_cnt,
    output logic [7:0]         tmo_cnt_total
`endif
);
    localparam int LW = $clog2(N+1);
    localparam int TW = $clog2(TMO+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic [LW-1:0] out_cnt_q, out_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;

    logic accept;
    logic xfer;
    logic in_flush;
    logic last_hit;
    logic tmo_hit;

    // Control outputs are gated by nreset so they are quiet while reset is held,
    // even before the first reset edge has settled the state register.
    assign accept   = nreset && (state_q == IDLE || state_q == LOAD);
    assign xfer     = bus.s_valid && accept;
    assign in_flush = nreset && (state_q == FLUSH);

    assign bus.s_ready  = accept;
    assign srt_data_i   = bus.s_data;
    assign srt_data_i_v = xfer;
    assign srt_flush    = in_flush;
    assign srt_rst      = !nreset || (state_q == CLEAR);
    assign busy         = nreset && (state_q != IDLE);
    assign err          = err_q;

    // Sorter output outside FLUSH is dropped here, so it is neither forwarded
    // nor counted.
    assign bus.m_data  = srt_data_o;
    assign bus.m_valid = srt_data_o_v && in_flush;
    assign last_hit    = bus.m_valid && (out_cnt_q == load_cnt_q - LW'(1));
    assign bus.m_last  = last_hit;
    assign tmo_hit     = (tmo_cnt_q == TW'(TMO-1));

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        out_cnt_d  = out_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    load_cnt_d = (state_q == IDLE) ? LW'(1) : load_cnt_q + LW'(1);
                    // A full sorter ends the batch just like s_last does.
                    if (bus.s_last || load_cnt_d == LW'(N)) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            FLUSH: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (bus.m_valid) begin
                    out_cnt_d = out_cnt_q + LW'(1);
                end
                // The final element takes priority over a coincident timeout.
                if (last_hit) begin
                    state_d = CLEAR;
                end else if (tmo_hit) begin
                    state_d = CLEAR;
                    err_d   = 1'b1;
                end
            end
            CLEAR: begin
                state_d    = IDLE;
                load_cnt_d = '0;
                out_cnt_d  = '0;
                tmo_cnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            out_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            out_cnt_q  <= out_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef SORTER_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    logic [15:0] batch_cnt_q, batch_cnt_d;
    logic [7:0]  tmo_tot_q, tmo_tot_d;

    always_comb begin
        batch_cnt_d = batch_cnt_q;
        tmo_tot_d   = tmo_tot_q;
        if (state_q == FLUSH && state_d == CLEAR) begin
            batch_cnt_d = sat_inc16(batch_cnt_q);
        end
        if (err_d) begin
            tmo_tot_d = sat_inc8(tmo_tot_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            batch_cnt_q <= '0;
            tmo_tot_q   <= '0;
        end else begin
            batch_cnt_q <= batch_cnt_d;
            tmo_tot_q   <= tmo_tot_d;
        end
    end

    assign batch_cnt     = batch_cnt_q;
    assign tmo_cnt_total = tmo_tot_q;
`endif
endmodule
